// File: rtl/nios2pio_msw_pkg.sv
// Shared types and widths for the Avalon-ST to on-chip RAM stream writer.
package nios2pio_msw_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } msw_state_e;

endpackage

// File: rtl/nios2pio_msw_packer.sv
// Byte-lane packer: gathers 8-bit beats into a little-endian 32-bit word with byteenables.
module nios2pio_msw_packer
  import nios2pio_msw_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              beat,
  input  logic [BYTE_W-1:0] data,
  input  logic              eop,
  output logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic [LANES-1:0]  be
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [LANES-1:0]  be_q, be_d;

  // Word/be including the current beat, so the completing byte is written without a bubble.
  always_comb begin
    word = pack_q;
    be   = be_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        word[i*BYTE_W +: BYTE_W] = data;
        be[i]                    = 1'b1;
      end
    end
  end

  assign word_ready = beat & ((lane_q == LANE_W'(LANES - 1)) | eop);

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    be_d   = be_q;
    if (clear || word_ready) begin
      lane_d = '0;
      pack_d = '0;
      be_d   = '0;
    end else if (beat) begin
      lane_d = lane_q + 1'b1;
      pack_d = word;
      be_d   = be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q <= '0;
      pack_q <= '0;
      be_q   <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
      be_q   <= be_d;
    end
  end

endmodule

// File: rtl/nios2pio_mem_stream_writer.sv
// Avalon-ST byte sink writing packed words sequentially into on-chip RAM.
// Define NIOS2PIO_MSW_WRAP_EN to wrap the address at the top instead of stopping on full.
module nios2pio_mem_stream_writer
  import nios2pio_msw_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned CNT_W  = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [BYTE_W-1:0] st_data,
  input  logic              st_valid,
  input  logic              st_eop,
  output logic              st_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LANES-1:0]  mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_writedata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [CNT_W-1:0]  word_count
);

  msw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  wbe_q, wbe_d;

  logic              beat, pack_clear, word_ready, at_top;
  logic [WORD_W-1:0] pack_word;
  logic [LANES-1:0]  pack_be;

  assign st_ready = (state_q == StRun);
  assign beat     = st_valid & st_ready;
  assign at_top   = (addr_q == ADDR_W'(DEPTH - 1));

  nios2pio_msw_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .beat       (beat),
    .data       (st_data),
    .eop        (st_eop),
    .word_ready (word_ready),
    .word       (pack_word),
    .be         (pack_be)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    full_d     = full_q;
    count_d    = count_q;
    wr_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wbe_d      = wbe_q;
    pack_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          addr_d     = base_addr;
          full_d     = 1'b0;
          count_d    = '0;
          pack_clear = 1'b1;
        end
      end
      StRun: begin
        if (word_ready) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = pack_word;
          wbe_d   = pack_be;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (at_top) begin
`ifdef NIOS2PIO_MSW_WRAP_EN
            addr_d  = '0;
`else
            full_d  = 1'b1;
            state_d = StDone;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (st_eop) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      full_q  <= 1'b0;
      count_q <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbe_q   <= wbe_d;
    end
  end

  assign mem_write      = wr_q;
  assign mem_chipselect = wr_q;
  assign mem_address    = waddr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = wbe_q;
  assign busy           = (state_q == StRun);
  assign done           = (state_q == StDone);
  assign full           = full_q;
  assign word_count     = count_q;

endmodule
